rib_arb: RTL and testbench

RIB_ARB -- requirements
Module: rib_arb

---
 rtl/rib_pkg.sv | 16 +
 rtl/rib_arb_if.sv | 22 ++
 rtl/rr_pick4.sv | 28 ++
 rtl/rib_arb.sv | 134 +++++++++++++
 tb/tb_rib_arb.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rib_pkg.sv
// Shared definitions for the rotating-priority bus arbiter (rib_arb).
package rib_pkg;

    localparam logic [1:0] GRANT0 = 2'd0;
    localparam logic [1:0] GRANT1 = 2'd1;
    localparam logic [1:0] GRANT2 = 2'd2;
    localparam logic [1:0] GRANT3 = 2'd3;

    localparam int TIMEOUT_CYCLES_DFLT = 255;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rib_arb_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// slave: arbiter side; master: requester/bus side.
interface rib_arb_if;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic       ack_i;
    logic [1:0] grant_o;
    logic       grant_vld_o;
    logic       hold_flag_o;
    logic       timeout_o;
    logic [1:0] err_master_o;

    modport slave (
        input  req_i, lock_i, ack_i,
        output grant_o, grant_vld_o, hold_flag_o, timeout_o, err_master_o
    );

    modport master (
        output req_i, lock_i, ack_i,
        input  grant_o, grant_vld_o, hold_flag_o, timeout_o, err_master_o
    );
endinterface

// File: rtl/rr_pick4.sv
// Four-way rotating-priority pick: last+1 is highest, last itself is lowest.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] win,
    output logic       any
);

    logic [1:0] idx;
    logic       found;

    // scan from last+1 upward, wrapping; offset 4 wraps back to last
    always_comb begin
        win   = last;
        idx   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rib_arb.sv
// Rotating-priority bus arbiter for four masters with lock and abort.
// Optional watchdog built in when RIB_ARB_TIMEOUT_EN is defined.
//
//   state | meaning
//   IDLE  | bus free, waiting for any request
//   BUSY  | grant_o owns the bus until ack (unlocked), abort or timeout
module rib_arb
    import rib_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT,
    parameter int TO_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    rib_arb_if.slave   bus
);

    state_t     state_q, state_nx;
    logic [1:0] grant_q, grant_nx;
    logic       vld_q, vld_nx;
    logic [1:0] last_q, last_nx;
    logic       new_grant;
    logic       release_now;
    logic       to_fire;
    logic [3:0] pick_req;
    logic [1:0] pick_last;
    logic [1:0] pick_win;
    logic       pick_any;

    // one picker shared by both states: IDLE uses the stored rotation,
    // a release uses the rotation updated to the current owner
    rr_pick4 u_pick (
        .req  (pick_req),
        .last (pick_last),
        .win  (pick_win),
        .any  (pick_any)
    );

    // next-state, next-grant and rotation update
    always_comb begin
        state_nx    = state_q;
        grant_nx    = grant_q;
        vld_nx      = vld_q;
        last_nx     = last_q;
        new_grant   = 1'b0;
        release_now = 1'b0;
        pick_req    = bus.req_i;
        pick_last   = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_nx  = pick_win;
                    vld_nx    = 1'b1;
                    new_grant = 1'b1;
                    state_nx  = BUSY;
                end
            end
            BUSY: begin
                // the outgoing owner is excluded so it cannot re-win at once
                pick_req    = bus.req_i & ~(4'b0001 << grant_q);
                pick_last   = grant_q;
                release_now = (bus.ack_i && !bus.lock_i[grant_q])
                              || !bus.req_i[grant_q] || to_fire;
                if (release_now) begin
                    last_nx = grant_q;
                    if (pick_any) begin
                        grant_nx  = pick_win;
                        new_grant = 1'b1;
                    end else begin
                        vld_nx   = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // arbitration state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= GRANT1;
            vld_q   <= 1'b0;
            last_q  <= GRANT3;
        end else begin
            state_q <= state_nx;
            grant_q <= grant_nx;
            vld_q   <= vld_nx;
            last_q  <= last_nx;
        end
    end

`ifdef RIB_ARB_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q;
    logic            to_q;
    logic [1:0]      err_q;

    assign to_fire = (state_q == BUSY) && (cnt_q == TO_W'(TIMEOUT_CYCLES));

    // watchdog: counts BUSY cycles since the last grant or ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
            err_q <= GRANT0;
        end else begin
            to_q <= to_fire;
            if (to_fire)
                err_q <= grant_q;
            if (new_grant || bus.ack_i || state_q != BUSY)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.timeout_o    = to_q;
    assign bus.err_master_o = err_q;
`else
    // timeout parameters only matter when the watchdog is built in
    localparam int unused_to_cfg = TIMEOUT_CYCLES + TO_W;

    assign to_fire          = 1'b0;
    assign bus.timeout_o    = 1'b0;
    assign bus.err_master_o = GRANT0;
`endif

    assign bus.grant_o     = grant_q;
    assign bus.grant_vld_o = vld_q;
    // master 1 is instruction fetch and never stalls the pipeline
    assign bus.hold_flag_o = bus.req_i[3] | bus.req_i[2] | bus.req_i[0];

endmodule

// File: tb/tb_rib_arb.sv
// Directed self-checking bench for rib_arb.
module tb_rib_arb;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    rib_arb_if bus_if ();

    rib_arb #(
        .TIMEOUT_CYCLES (10),
        .TO_W           (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input int g, input int v);
        chk({tag, "_vld"}, int'(bus_if.grant_vld_o), v);
        if (v == 1)
            chk({tag, "_grant"}, int'(bus_if.grant_o), g);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus_if.req_i  = 4'b0000;
        bus_if.lock_i = 4'b0000;
        bus_if.ack_i  = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_grant", int'(bus_if.grant_o), 1);
        chk("rst_vld", int'(bus_if.grant_vld_o), 0);
        chk("rst_to", int'(bus_if.timeout_o), 0);
        chk("rst_err", int'(bus_if.err_master_o), 0);
        chk("rst_hold", int'(bus_if.hold_flag_o), 0);
        @(negedge clk);
        rst = 1'b1;

        // all four request, one ack per grant, no bubble
        bus_if.req_i = 4'b1111;
        step(1);
        chk_grant("rr_first", 0, 1);
        chk("rr_hold", int'(bus_if.hold_flag_o), 1);
        bus_if.ack_i = 1'b1;
        step(1); chk_grant("rr_g1", 1, 1);
        step(1); chk_grant("rr_g2", 2, 1);
        step(1); chk_grant("rr_g3", 3, 1);
        step(1); chk_grant("rr_g0", 0, 1);
        bus_if.ack_i = 1'b0;
        bus_if.req_i = 4'b0000;
        step(1); chk_grant("rr_idle", 0, 0);

        // instruction fetch only: grant 1, no stall
        bus_if.req_i = 4'b0010;
        #1 chk("if_hold_pre", int'(bus_if.hold_flag_o), 0);
        step(1);
        chk_grant("if_grant", 1, 1);
        chk("if_hold", int'(bus_if.hold_flag_o), 0);
        bus_if.req_i = 4'b0000;
        step(1); chk_grant("if_idle", 0, 0);

        // lock keeps master 2 across three acks
        bus_if.req_i  = 4'b1100;
        bus_if.lock_i = 4'b0100;
        step(1); chk_grant("lk_grant", 2, 1);
        bus_if.ack_i = 1'b1;
        step(1); chk_grant("lk_ack1", 2, 1);
        step(1); chk_grant("lk_ack2", 2, 1);
        step(1); chk_grant("lk_ack3", 2, 1);
        bus_if.lock_i = 4'b0000;
        step(1); chk_grant("lk_unlock", 3, 1);
        bus_if.ack_i = 1'b0;
        bus_if.req_i = 4'b0000;
        step(1); chk_grant("lk_idle", 0, 0);

        // abort: master 0 drops request, master 3 takes over same edge
        bus_if.req_i = 4'b0001;
        step(1); chk_grant("ab_g0", 0, 1);
        bus_if.req_i = 4'b1000;
        step(1); chk_grant("ab_g3", 3, 1);

        // released master keeps requesting: it drops to lowest priority
        bus_if.req_i = 4'b1001;
        bus_if.ack_i = 1'b1;
        step(1); chk_grant("lp_g0", 0, 1);
        step(1); chk_grant("lp_g3", 3, 1);
        bus_if.ack_i = 1'b0;
        bus_if.req_i = 4'b0000;
        step(1); chk_grant("lp_idle", 0, 0);

        // sole requester released by ack goes through IDLE once
        bus_if.req_i = 4'b0100;
        step(1); chk_grant("so_g2", 2, 1);
        bus_if.ack_i = 1'b1;
        step(1); chk_grant("so_idle", 0, 0);
        bus_if.ack_i = 1'b0;
        step(1); chk_grant("so_regrant", 2, 1);
        bus_if.req_i = 4'b0000;
        step(1); chk_grant("so_drop", 0, 0);

        // ack while idle is ignored
        bus_if.ack_i = 1'b1;
        step(1); chk_grant("ia_idle", 0, 0);
        bus_if.ack_i = 1'b0;

        // master 3 holds the bus with no ack
        bus_if.req_i = 4'b1000;
        step(1); chk_grant("to_grant", 3, 1);
`ifdef RIB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk("to_quiet", int'(bus_if.timeout_o), 0);
        end
        step(1);
        chk("to_pulse", int'(bus_if.timeout_o), 1);
        chk("to_err", int'(bus_if.err_master_o), 3);
        chk_grant("to_release", 0, 0);
        step(1);
        chk("to_once", int'(bus_if.timeout_o), 0);
        chk_grant("to_regrant", 3, 1);
`else
        step(20);
        chk_grant("nt_held", 3, 1);
        chk("nt_to", int'(bus_if.timeout_o), 0);
        chk("nt_err", int'(bus_if.err_master_o), 0);
`endif
        bus_if.req_i = 4'b0000;
        step(1); chk_grant("to_idle", 0, 0);

        // asynchronous reset mid-BUSY
        bus_if.req_i = 4'b0100;
        step(1); chk_grant("ar_g2", 2, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_vld", int'(bus_if.grant_vld_o), 0);
        chk("ar_grant", int'(bus_if.grant_o), 1);
        chk("ar_to", int'(bus_if.timeout_o), 0);
        @(negedge clk);
        rst = 1'b1;
        bus_if.req_i = 4'b1001;
        step(1); chk_grant("ar_first", 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
